// File: rtl/mini_mips_main_ctrl.sv
// Multicycle MIPS-style main control FSM with registered Moore outputs decoded
// from the next state, so strobes are valid in the cycle the state is entered.
module mini_mips_main_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] opcode,
  input  logic       mem_ready,
  output logic [2:0] ALUOp,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       pc_write,
  output logic       pc_write_eq,
  output logic       pc_write_ne,
  output logic [1:0] pc_src,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       illegal,
  output logic [3:0] state_dbg
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_EXEC_I   = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_MEM_WR   = 4'd7,
    S_WB_R     = 4'd8,
    S_WB_I     = 4'd9,
    S_WB_MEM   = 4'd10,
    S_BRANCH   = 4'd11,
    S_JUMP     = 4'd12
  } state_e;

  localparam logic [3:0] OP_R    = 4'd0;
  localparam logic [3:0] OP_ADDI = 4'd1;
  localparam logic [3:0] OP_ANDI = 4'd2;
  localparam logic [3:0] OP_ORI  = 4'd3;
  localparam logic [3:0] OP_SLTI = 4'd4;
  localparam logic [3:0] OP_LW   = 4'd5;
  localparam logic [3:0] OP_SW   = 4'd6;
  localparam logic [3:0] OP_BEQ  = 4'd7;
  localparam logic [3:0] OP_BNE  = 4'd8;
  localparam logic [3:0] OP_J    = 4'd9;

  state_e     state_q, state_d;
  logic [3:0] opcode_q, opcode_d, op_eff;

  logic [2:0] alu_op_q, alu_op_d;
  logic       src_a_q, src_a_d;
  logic [1:0] src_b_q, src_b_d;
  logic       jump_q, jump_d;
  logic       pc_eq_q, pc_eq_d;
  logic       pc_ne_q, pc_ne_d;
  logic [1:0] pc_src_q, pc_src_d;
  logic       fetch_q, fetch_d;
  logic       mem_read_q, mem_read_d;
  logic       mem_write_q, mem_write_d;
  logic       reg_write_q, reg_write_d;
  logic       reg_dst_q, reg_dst_d;
  logic       mem_to_reg_q, mem_to_reg_d;
  logic       illegal_q, illegal_d;

  // The live opcode is only meaningful in DECODE; afterwards the captured copy is used.
  assign op_eff = (state_q == S_DECODE) ? opcode : opcode_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_R:                              state_d = S_EXEC_R;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_EXEC_I;
          OP_LW, OP_SW:                      state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE:                    state_d = S_BRANCH;
          OP_J:                              state_d = S_JUMP;
          default:                           state_d = S_FETCH;
        endcase
      end
      S_EXEC_R:   state_d = S_WB_R;
      S_EXEC_I:   state_d = S_WB_I;
      S_MEM_ADDR: state_d = (op_eff == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (mem_ready) state_d = S_WB_MEM;
      S_MEM_WR:   if (mem_ready) state_d = S_FETCH;
      S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_JUMP: state_d = S_FETCH;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    if (state_d == S_FETCH || state_d == S_IDLE) opcode_d = '0;
    else if (state_q == S_DECODE)                opcode_d = opcode;
    else                                         opcode_d = opcode_q;
  end

  always_comb begin
    alu_op_d     = '0;
    src_a_d      = 1'b0;
    src_b_d      = '0;
    jump_d       = 1'b0;
    pc_eq_d      = 1'b0;
    pc_ne_d      = 1'b0;
    pc_src_d     = '0;
    fetch_d      = 1'b0;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    reg_write_d  = 1'b0;
    reg_dst_d    = 1'b0;
    mem_to_reg_d = 1'b0;
    illegal_d    = 1'b0;
    case (state_d)
      S_FETCH: begin
        mem_read_d = 1'b1;
        src_b_d    = 2'b01;
        alu_op_d   = 3'b001;
        fetch_d    = 1'b1;
        illegal_d  = (state_q == S_DECODE);
      end
      S_DECODE: begin
        src_b_d  = 2'b11;
        alu_op_d = 3'b001;
      end
      S_EXEC_R: src_a_d = 1'b1;
      S_EXEC_I: begin
        src_a_d = 1'b1;
        src_b_d = 2'b10;
        case (op_eff)
          OP_ADDI: alu_op_d = 3'b001;
          OP_ANDI: alu_op_d = 3'b011;
          OP_ORI:  alu_op_d = 3'b100;
          default: alu_op_d = 3'b101;
        endcase
      end
      S_MEM_ADDR: begin
        src_a_d  = 1'b1;
        src_b_d  = 2'b10;
        alu_op_d = 3'b001;
      end
      S_MEM_RD: mem_read_d  = 1'b1;
      S_MEM_WR: mem_write_d = 1'b1;
      S_WB_R: begin
        reg_write_d = 1'b1;
        reg_dst_d   = 1'b1;
      end
      S_WB_I: reg_write_d = 1'b1;
      S_WB_MEM: begin
        reg_write_d  = 1'b1;
        mem_to_reg_d = 1'b1;
      end
      S_BRANCH: begin
        src_a_d  = 1'b1;
        alu_op_d = 3'b010;
        pc_src_d = 2'b01;
        pc_eq_d  = (op_eff == OP_BEQ);
        pc_ne_d  = (op_eff == OP_BNE);
      end
      S_JUMP: begin
        jump_d   = 1'b1;
        pc_src_d = 2'b10;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      opcode_q     <= '0;
      alu_op_q     <= '0;
      src_a_q      <= 1'b0;
      src_b_q      <= '0;
      jump_q       <= 1'b0;
      pc_eq_q      <= 1'b0;
      pc_ne_q      <= 1'b0;
      pc_src_q     <= '0;
      fetch_q      <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      reg_write_q  <= 1'b0;
      reg_dst_q    <= 1'b0;
      mem_to_reg_q <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      opcode_q     <= opcode_d;
      alu_op_q     <= alu_op_d;
      src_a_q      <= src_a_d;
      src_b_q      <= src_b_d;
      jump_q       <= jump_d;
      pc_eq_q      <= pc_eq_d;
      pc_ne_q      <= pc_ne_d;
      pc_src_q     <= pc_src_d;
      fetch_q      <= fetch_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      reg_write_q  <= reg_write_d;
      reg_dst_q    <= reg_dst_d;
      mem_to_reg_q <= mem_to_reg_d;
      illegal_q    <= illegal_d;
    end
  end

  // Fetch completion is only known in-cycle, so the registered FETCH flag is
  // qualified by mem_ready to pulse ir_write/pc_write on the completing cycle.
  assign ir_write    = fetch_q & mem_ready;
  assign pc_write    = jump_q | (fetch_q & mem_ready);
  assign ALUOp       = alu_op_q;
  assign alu_src_a   = src_a_q;
  assign alu_src_b   = src_b_q;
  assign pc_write_eq = pc_eq_q;
  assign pc_write_ne = pc_ne_q;
  assign pc_src      = pc_src_q;
  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign reg_write   = reg_write_q;
  assign reg_dst     = reg_dst_q;
  assign mem_to_reg  = mem_to_reg_q;
  assign illegal     = illegal_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_mini_mips_main_ctrl.sv
// Self-checking bench: instruction sequences expanded into expected per-cycle
// state/output snapshots from the opcode class and wait counts.
module tb_mini_mips_main_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] opcode;
  logic       mem_ready;
  logic [2:0] ALUOp;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       pc_write, pc_write_eq, pc_write_ne;
  logic [1:0] pc_src;
  logic       ir_write, mem_read, mem_write, reg_write, reg_dst, mem_to_reg, illegal;
  logic [3:0] state_dbg;

  mini_mips_main_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .ALUOp(ALUOp), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .pc_write(pc_write), .pc_write_eq(pc_write_eq), .pc_write_ne(pc_write_ne),
    .pc_src(pc_src), .ir_write(ir_write), .mem_read(mem_read),
    .mem_write(mem_write), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .illegal(illegal), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct {
    int       st;
    logic [3:0] op;
    bit       rdy;
    bit       ill;
  } step_t;

  step_t q[$];
  bit    pend_ill;
  int    tests;
  int    fails;

  // Snapshot layout: state, ALUOp, src_a, src_b, pc_write, eq, ne, pc_src,
  // ir_write, mem_read, mem_write, reg_write, reg_dst, mem_to_reg, illegal.
  function automatic logic [21:0] observed();
    return {state_dbg, ALUOp, alu_src_a, alu_src_b, pc_write, pc_write_eq,
            pc_write_ne, pc_src, ir_write, mem_read, mem_write, reg_write,
            reg_dst, mem_to_reg, illegal};
  endfunction

  function automatic logic [21:0] expect_vec(step_t s);
    logic [3:0] st;
    logic [2:0] aop;
    logic       a, pw, eq, ne, ir, mr, mw, rw, rd, m2r, il;
    logic [1:0] b, ps;
    st = s.st[3:0];
    aop = 3'd0; a = 0; b = 2'd0; pw = 0; eq = 0; ne = 0; ps = 2'd0;
    ir = 0; mr = 0; mw = 0; rw = 0; rd = 0; m2r = 0; il = 0;
    case (s.st)
      1:  begin mr = 1; b = 2'd1; aop = 3'd1; ir = s.rdy; pw = s.rdy; il = s.ill; end
      2:  begin b = 2'd3; aop = 3'd1; end
      3:  a = 1;
      4:  begin
            a = 1; b = 2'd2;
            aop = (s.op == 1) ? 3'd1 : (s.op == 2) ? 3'd3 : (s.op == 3) ? 3'd4 : 3'd5;
          end
      5:  begin a = 1; b = 2'd2; aop = 3'd1; end
      6:  mr = 1;
      7:  mw = 1;
      8:  begin rw = 1; rd = 1; end
      9:  rw = 1;
      10: begin rw = 1; m2r = 1; end
      11: begin a = 1; aop = 3'd2; ps = 2'd1; eq = (s.op == 7); ne = (s.op == 8); end
      12: begin pw = 1; ps = 2'd2; end
      default: ;
    endcase
    return {st, aop, a, b, pw, eq, ne, ps, ir, mr, mw, rw, rd, m2r, il};
  endfunction

  function automatic step_t mk(int st, logic [3:0] op, bit rdy, bit ill);
    step_t s;
    s.st = st; s.op = op; s.rdy = rdy; s.ill = ill;
    return s;
  endfunction

  // One instruction: fetch (fw waits), decode, then the opcode's path.
  task automatic build(input logic [3:0] op, input int fw, input int mw);
    for (int i = 0; i < fw; i++) begin
      q.push_back(mk(1, op, 1'b0, (i == 0) ? pend_ill : 1'b0));
    end
    q.push_back(mk(1, op, 1'b1, (fw == 0) ? pend_ill : 1'b0));
    pend_ill = 0;
    q.push_back(mk(2, op, 1'($urandom_range(0, 1)), 1'b0));
    if (op == 0) begin
      q.push_back(mk(3, op, 1'($urandom_range(0, 1)), 1'b0));
      q.push_back(mk(8, op, 1'($urandom_range(0, 1)), 1'b0));
    end else if (op <= 4) begin
      q.push_back(mk(4, op, 1'($urandom_range(0, 1)), 1'b0));
      q.push_back(mk(9, op, 1'($urandom_range(0, 1)), 1'b0));
    end else if (op == 5 || op == 6) begin
      q.push_back(mk(5, op, 1'($urandom_range(0, 1)), 1'b0));
      for (int i = 0; i < mw; i++) q.push_back(mk((op == 5) ? 6 : 7, op, 1'b0, 1'b0));
      q.push_back(mk((op == 5) ? 6 : 7, op, 1'b1, 1'b0));
      if (op == 5) q.push_back(mk(10, op, 1'($urandom_range(0, 1)), 1'b0));
    end else if (op == 7 || op == 8) begin
      q.push_back(mk(11, op, 1'($urandom_range(0, 1)), 1'b0));
    end else if (op == 9) begin
      q.push_back(mk(12, op, 1'($urandom_range(0, 1)), 1'b0));
    end else begin
      pend_ill = 1;
    end
  endtask

  // Drives one cycle's inputs, samples outputs mid-cycle, advances one clock.
  task automatic drive_step(input step_t s, output logic [21:0] got);
    opcode    = (s.st == 2) ? s.op : 4'($urandom_range(0, 15));
    mem_ready = s.rdy;
    #1;
    got = observed();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [21:0] got;
    rst_n = 1'b0; mem_ready = 1'b1; opcode = 4'd0; pend_ill = 0;
    repeat (2) @(posedge clk);
    #3;
    got = observed();
    tests++;
    if (got !== 22'd0) begin
      fails++; $display("FAIL reset_hold: got %h expected %h", got, 22'd0);
    end
    rst_n = 1'b1;
    #1;
    got = observed();
    tests++;
    if (got !== 22'd0) begin
      fails++; $display("FAIL reset_release_idle: got %h expected %h", got, 22'd0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_fetch_rtype();
    step_t s; logic [21:0] got, exp;
    build(4'd0, 0, 0);
    build(4'd2, 1, 0);
    while (q.size() > 0) begin
      s = q.pop_front(); exp = expect_vec(s); drive_step(s, got);
      tests++;
      if (got !== exp) begin
        fails++; $display("FAIL rtype_andi st=%0d: got %h expected %h", s.st, got, exp);
      end
    end
  endtask

  task automatic test_mem_wait();
    step_t s; logic [21:0] got, exp;
    build(4'd5, 0, 2);
    build(4'd6, 2, 3);
    while (q.size() > 0) begin
      s = q.pop_front(); exp = expect_vec(s); drive_step(s, got);
      tests++;
      if (got !== exp) begin
        fails++; $display("FAIL lw_sw_wait st=%0d: got %h expected %h", s.st, got, exp);
      end
    end
  endtask

  task automatic test_branch_illegal();
    step_t s; logic [21:0] got, exp;
    build(4'd8, 0, 0);
    build(4'd7, 0, 0);
    build(4'd12, 0, 0);
    build(4'd9, 1, 0);
    build(4'd15, 0, 0);
    build(4'd1, 0, 0);
    while (q.size() > 0) begin
      s = q.pop_front(); exp = expect_vec(s); drive_step(s, got);
      tests++;
      if (got !== exp) begin
        fails++; $display("FAIL branch_illegal st=%0d: got %h expected %h", s.st, got, exp);
      end
    end
  endtask

  task automatic test_random();
    step_t s; logic [21:0] got, exp;
    for (int n = 0; n < 60; n++) begin
      build(4'($urandom_range(0, 15)), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
    end
    while (q.size() > 0) begin
      s = q.pop_front(); exp = expect_vec(s); drive_step(s, got);
      tests++;
      if (got !== exp) begin
        fails++; $display("FAIL random st=%0d op=%0d: got %h expected %h", s.st, s.op, got, exp);
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    step_t s; logic [21:0] got, exp;
    build(4'd0, 0, 0);
    q.push_back(mk(1, 4'd0, 1'b0, pend_ill));
    q.push_back(mk(1, 4'd0, 1'b0, 1'b0));
    while (q.size() > 0) begin
      s = q.pop_front(); exp = expect_vec(s); drive_step(s, got);
      tests++;
      if (got !== exp) begin
        fails++; $display("FAIL pre_reset st=%0d: got %h expected %h", s.st, got, exp);
      end
    end
    mem_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    got = observed();
    tests++;
    if (got !== 22'd0) begin
      fails++; $display("FAIL async_reset_mid_wait: got %h expected %h", got, 22'd0);
    end
    @(posedge clk);
    #4;
    rst_n = 1'b1;
    #1;
    got = observed();
    tests++;
    if (got !== 22'd0) begin
      fails++; $display("FAIL post_reset_idle: got %h expected %h", got, 22'd0);
    end
    @(posedge clk);
    #1;
    pend_ill = 0;
    build(4'd9, 0, 0);
    build(4'd5, 1, 1);
    while (q.size() > 0) begin
      s = q.pop_front(); exp = expect_vec(s); drive_step(s, got);
      tests++;
      if (got !== exp) begin
        fails++; $display("FAIL resume_after_reset st=%0d: got %h expected %h", s.st, got, exp);
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_fetch_rtype();
    test_mem_wait();
    test_branch_illegal();
    test_random();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
